peak_dpu_lsu: RTL and testbench
===============================

# peak_dpu_lsu

Load/store execution unit that sits directly downstream of the load/store decoder in the DPU. It accepts one decoded ld/st operation at a time: 3-bit ls op, rs1/rs2 operand data, immediate and destination register. It computes the effective address, drives a single-outstanding request/grant/response data bus with byte enables, and for loads returns the extracted, sign- or zero-extended result to register writeback.

## Interface
- RSP_TIMEOUT, 255: max cycles spent in WAIT_RSP before abort; 0 disables the timeout.
- clk  input  1  core clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- ls_vld  input  1  decoded ld/st op valid
- ls_rdy  output  1  unit can accept an op; equals state==IDLE
- ls_op  input  3  LB=0 LH=1 LW=2 LBU=3 LHU=4 SB=5 SH=6 SW=7
- ls_rs1_data  input  32  base register value
- ls_rs2_data  input  32  store data
- ls_imm  input  32  sign-extended offset
- ls_wr_addr  input  5  load destination register
- bus_req  output  1  bus request
- bus_we  output  1  1=store, 0=load
- bus_addr  output  32  word address {ea[31:2],2'b00}
- bus_be  output  4  byte lane enables
- bus_wdata  output  32  lane-replicated store data
- bus_gnt  input  1  request accepted this cycle
- bus_rsp_vld  input  1  response/ack valid
- bus_rdata  input  32  load data word
- wb_vld  output  1  one-cycle writeback strobe
- wb_addr  output  5  writeback register
- wb_data  output  32  writeback data
- bus_err  output  1  one-cycle pulse on response timeout
- misalign_exc  output  1  one-cycle misalignment exception pulse
- exc_addr  output  32  faulting effective address

## Operation
- States: IDLE, REQ, WAIT_RSP.
- IDLE: on ls_vld&&ls_rdy, register op, wr_addr, rs2, ea=rs1+imm (mod 2^32). Go to REQ, or raise the misaligned exception (see Configuration).
- REQ: bus_req=1; bus_we, bus_addr, bus_be and bus_wdata are held stable until bus_gnt. On gnt go to WAIT_RSP and clear the timeout counter. bus_rsp_vld is ignored in REQ.
- WAIT_RSP: wait for bus_rsp_vld, which acts as ack for stores.
  - On rsp for a load: register the extracted data, pulse wb_vld if wr_addr!=0, go to IDLE.
  - On rsp for a store: go to IDLE with no writeback.
  - If the counter reaches RSP_TIMEOUT (and RSP_TIMEOUT != 0): pulse bus_err, no writeback, go to IDLE.
- Lanes, with a=ea[1:0]:
  - Byte ops: be=4'b0001<<a; wdata={4{rs2[7:0]}}.
  - Half ops: be=a[1]?4'b1100:4'b0011; wdata={2{rs2[15:0]}}.
  - Word ops: be=4'b1111; wdata=rs2.
- Load extract:
  - LB/LBU: byte a of rdata, sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: halfword a[1], sign-extended (LH) or zero-extended (LHU).
  - LW: full word.
- Misaligned: half op with a[0]=1; word op with a!=0.

## Timing
- Reset values: state IDLE, ls_rdy=1. bus_req, bus_we, bus_be, wb_vld, bus_err and misalign_exc are 0. bus_addr, bus_wdata, wb_addr, wb_data and exc_addr are 0.
- Accept at edge T0; bus_req high from T0+1.
- Minimum load latency: gnt in T0+1, rsp_vld in T0+2, wb_vld high in T0+3. ls_rdy is 1 in T0+3, so back-to-back ops are accepted.
- wb_vld, bus_err and misalign_exc are single-cycle pulses and are never asserted together.
- rsp_vld in the same cycle the timeout is reached: the response wins, with no bus_err.
- Reset mid-operation: bus_req drops asynchronously, the in-flight op is discarded, and no wb_vld is issued.

## Configuration
- PEAK_LSU_MISALIGN_EXC_EN defined:
  - A misaligned op causes no bus access.
  - misalign_exc pulses at T0+1, exc_addr holds ea, and the state returns to IDLE (ls_rdy=1 at T0+1).
  - No writeback.
- Undefined:
  - ea low bits are forced to alignment (half: a[0]=0; word: a=0) and the access proceeds normally.
  - misalign_exc and exc_addr are tied to 0.

## Test plan
- LW, rs1=0x1000, imm=4, gnt immediate, rsp rdata=0xDEADBEEF -> bus_addr=0x1004, be=4'b1111, wb_vld at T0+3, wb_data=0xDEADBEEF.
- LB, ea=0x2003, rdata=0x80FFFFFF -> be=4'b1000, wb_data=0xFFFFFF80; repeat as LBU -> 0x00000080.
- SH, ea=0x3002, rs2=0x1234ABCD, gnt held off 3 cycles -> bus_req stable 4 cycles, be=4'b1100, wdata=0xABCDABCD, no wb_vld.
- LW with wr_addr=0, then LHU with RSP_TIMEOUT=4 and rsp withheld -> no wb_vld for the first op; bus_err pulse after 4 WAIT_RSP cycles, then ls_rdy=1.
- LH, ea=0x4001 -> with macro: misalign_exc pulse, exc_addr=0x4001, bus_req never asserted; without macro: bus_addr=0x4000, be=4'b0011.
- Assert rst during WAIT_RSP -> bus_req=0 immediately, no wb_vld after release, ls_rdy=1.

Source files
------------

// File: rtl/peak_dpu_lsu.sv
// peak_dpu_lsu: load/store execution unit for the DPU.
// Takes one decoded ld/st op at a time, computes ea = rs1 + imm,
// runs a single-outstanding req/gnt/rsp bus transaction with byte
// enables and returns the extracted, sign/zero-extended load data.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   ls_*              decoded op in (vld/rdy handshake)
//   bus_*             data bus request/grant/response
//   wb_*              register writeback strobe, address, data
//   bus_err           response timeout pulse
//   misalign_exc      misaligned access pulse, exc_addr = faulting ea
//
// Parameter RSP_TIMEOUT: WAIT_RSP cycle limit, 0 disables it.
// Macro PEAK_LSU_MISALIGN_EXC_EN: misaligned ops raise misalign_exc
// instead of being forced to alignment.
module peak_dpu_lsu #(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_vld,
    output logic        ls_rdy,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_rs1_data,
    input  logic [31:0] ls_rs2_data,
    input  logic [31:0] ls_imm,
    input  logic [4:0]  ls_wr_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rsp_vld,
    input  logic [31:0] bus_rdata,
    output logic        wb_vld,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        bus_err,
    output logic        misalign_exc,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int CW = (RSP_TIMEOUT < 2) ? 1
                                          : $clog2(RSP_TIMEOUT + 1);
    // Last counter value before the timeout fires.
    localparam logic [CW-1:0] TO_LAST =
        (RSP_TIMEOUT == 0) ? '0 : CW'(RSP_TIMEOUT - 1);

    function automatic logic [1:0] op_size(input logic [2:0] op);
        logic [1:0] sz;
        sz = SZ_W;
        unique case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_B;
            OP_LH, OP_LHU, OP_SH: sz = SZ_H;
            default:              sz = SZ_W;
        endcase
        return sz;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  a_q, a_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        wb_vld_q, wb_vld_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        bus_err_q, bus_err_d;

    logic [31:0] ea_raw;
    logic [31:0] ea;
    logic [1:0]  in_sz;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        in_we;
    logic        exc_fire;

    // Accept-side address and lane generation.
    always_comb begin
        ea_raw   = ls_rs1_data + ls_imm;
        in_sz    = op_size(ls_op);
        in_we    = (ls_op == OP_SB) || (ls_op == OP_SH) ||
                   (ls_op == OP_SW);
        ea       = ea_raw;
`ifndef PEAK_LSU_MISALIGN_EXC_EN
        // No exception path: silently align the access.
        if (in_sz == SZ_H) begin
            ea[0] = 1'b0;
        end else if (in_sz == SZ_W) begin
            ea[1:0] = 2'b00;
        end
`endif
        in_be    = 4'b0000;
        in_wdata = 32'h0;
        unique case (in_sz)
            SZ_B: begin
                in_be    = 4'b0001 << ea[1:0];
                in_wdata = {4{ls_rs2_data[7:0]}};
            end
            SZ_H: begin
                in_be    = ea[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{ls_rs2_data[15:0]}};
            end
            default: begin
                in_be    = 4'b1111;
                in_wdata = ls_rs2_data;
            end
        endcase
    end

`ifdef PEAK_LSU_MISALIGN_EXC_EN
    logic        misal;
    logic        misalign_q, misalign_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    assign misal = ((in_sz == SZ_H) && ea_raw[0]) ||
                   ((in_sz == SZ_W) && (ea_raw[1:0] != 2'b00));
    assign exc_fire = misal;

    always_comb begin
        misalign_d = (state_q == IDLE) && ls_vld && misal;
        exc_addr_d = misalign_d ? ea_raw : exc_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
            exc_addr_q <= 32'h0;
        end else begin
            misalign_q <= misalign_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    assign misalign_exc = misalign_q;
    assign exc_addr     = exc_addr_q;
`else
    assign exc_fire     = 1'b0;
    assign misalign_exc = 1'b0;
    assign exc_addr     = 32'h0;
`endif

    // Load data extraction from the registered lane offset.
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    always_comb begin
        ld_b   = bus_rdata[8*a_q +: 8];
        ld_h   = a_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_ext = bus_rdata;
        unique case (op_q)
            OP_LB:   ld_ext = {{24{ld_b[7]}}, ld_b};
            OP_LBU:  ld_ext = {24'h0, ld_b};
            OP_LH:   ld_ext = {{16{ld_h[15]}}, ld_h};
            OP_LHU:  ld_ext = {16'h0, ld_h};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wr_addr_d = wr_addr_q;
        addr_d    = addr_q;
        a_d       = a_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        wb_vld_d  = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        bus_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ls_vld && !exc_fire) begin
                    op_d      = ls_op;
                    wr_addr_d = ls_wr_addr;
                    addr_d    = ea[31:2];
                    a_d       = ea[1:0];
                    we_d      = in_we;
                    be_d      = in_be;
                    wdata_d   = in_wdata;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    cnt_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response in the timeout cycle still wins.
                if (bus_rsp_vld) begin
                    state_d = IDLE;
                    if (!we_q && (wr_addr_q != 5'd0)) begin
                        wb_vld_d  = 1'b1;
                        wb_addr_d = wr_addr_q;
                        wb_data_d = ld_ext;
                    end
                end else if ((RSP_TIMEOUT != 0) &&
                             (cnt_q == TO_LAST)) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 3'd0;
            wr_addr_q <= 5'd0;
            addr_q    <= 30'h0;
            a_q       <= 2'd0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
            cnt_q     <= '0;
            wb_vld_q  <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wr_addr_q <= wr_addr_d;
            addr_q    <= addr_d;
            a_q       <= a_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            wb_vld_q  <= wb_vld_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ls_rdy    = (state_q == IDLE);
    assign bus_req   = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q, 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign wb_vld    = wb_vld_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_peak_dpu_lsu.sv
// Scoreboard bench for peak_dpu_lsu: directed ops push expected bus
// requests / writebacks / errors; a negedge monitor pops and compares.
module tb_peak_dpu_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ls_vld = 1'b0;
    logic        ls_rdy;
    logic [2:0]  ls_op = 3'd0;
    logic [31:0] ls_rs1_data = 32'h0;
    logic [31:0] ls_rs2_data = 32'h0;
    logic [31:0] ls_imm = 32'h0;
    logic [4:0]  ls_wr_addr = 5'd0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rsp_vld = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        wb_vld;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        bus_err;
    logic        misalign_exc;
    logic [31:0] exc_addr;

    peak_dpu_lsu #(.RSP_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ls_vld(ls_vld), .ls_rdy(ls_rdy), .ls_op(ls_op),
        .ls_rs1_data(ls_rs1_data), .ls_rs2_data(ls_rs2_data),
        .ls_imm(ls_imm), .ls_wr_addr(ls_wr_addr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rsp_vld(bus_rsp_vld),
        .bus_rdata(bus_rdata),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
        .bus_err(bus_err), .misalign_exc(misalign_exc),
        .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    req_t        req_q[$];
    wb_t         wb_q[$];
    int          err_q[$];
    logic [31:0] exc_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event want none", nm);
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_req && bus_gnt) begin
                if (req_q.size() == 0) begin
                    unexpected("bus_req");
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_addr", bus_addr, r.addr);
                    chk("req_be", 32'(bus_be), 32'(r.be));
                    chk("req_we", 32'(bus_we), 32'(r.we));
                    if (r.we) chk("req_wdata", bus_wdata, r.wdata);
                end
            end
            if (wb_vld) begin
                if (wb_q.size() == 0) begin
                    unexpected("wb_vld");
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_addr", 32'(wb_addr), 32'(w.addr));
                    chk("wb_data", wb_data, w.data);
                end
            end
            if (bus_err) begin
                if (err_q.size() == 0) unexpected("bus_err");
                else begin
                    int e;
                    e = err_q.pop_front();
                    chk("err_excl", 32'(wb_vld | misalign_exc), 0);
                end
            end
            if (misalign_exc) begin
                if (exc_q.size() == 0) unexpected("misalign_exc");
                else begin
                    logic [31:0] x;
                    x = exc_q.pop_front();
                    chk("exc_addr", exc_addr, x);
                    chk("exc_excl", 32'(wb_vld | bus_err), 0);
                end
            end
        end
    end

    task automatic push_req(input logic [31:0] a, input logic [3:0] be,
                            input logic we, input logic [31:0] wd);
        req_t r;
        r.addr = a; r.be = be; r.we = we; r.wdata = wd;
        req_q.push_back(r);
    endtask

    task automatic push_wb(input logic [4:0] a, input logic [31:0] d);
        wb_t w;
        w.addr = a; w.data = d;
        wb_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op; returns positioned in cycle T0+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [4:0] wr);
        for (int i = 0; i < 20 && !ls_rdy; i++) step();
        chk("ls_rdy_before_issue", 32'(ls_rdy), 1);
        ls_vld = 1'b1; ls_op = op; ls_rs1_data = rs1;
        ls_rs2_data = rs2; ls_imm = imm; ls_wr_addr = wr;
        step();
        ls_vld = 1'b0;
    endtask

    task automatic grant(input int dly);
        for (int i = 0; i < dly; i++) step();
        chk("req_at_gnt", 32'(bus_req), 1);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [31:0] d);
        for (int i = 0; i < dly; i++) step();
        bus_rsp_vld = 1'b1;
        bus_rdata = d;
        step();
        bus_rsp_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_ls_rdy", 32'(ls_rdy), 1);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_we", 32'(bus_we), 0);
        chk("rst_bus_be", 32'(bus_be), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_wb_vld", 32'(wb_vld), 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_misalign", 32'(misalign_exc), 0);
        chk("rst_exc_addr", exc_addr, 0);
        #20;
        rst = 1'b0;
        step();

        // LW 0x1004, minimum latency
        push_req(32'h1004, 4'b1111, 1'b0, 32'h0);
        push_wb(5'd5, 32'hDEADBEEF);
        issue(3'd2, 32'h1000, 32'h0, 32'h4, 5'd5);
        chk("lw_req_t1", 32'(bus_req), 1);
        grant(0);
        respond(0, 32'hDEADBEEF);
        chk("lw_wb_t3", 32'(wb_vld), 1);
        chk("lw_rdy_t3", 32'(ls_rdy), 1);

        // LB / LBU byte 3
        push_req(32'h2000, 4'b1000, 1'b0, 32'h0);
        push_wb(5'd6, 32'hFFFFFF80);
        issue(3'd0, 32'h2000, 32'h0, 32'h3, 5'd6);
        grant(0);
        respond(0, 32'h80FFFFFF);
        push_req(32'h2000, 4'b1000, 1'b0, 32'h0);
        push_wb(5'd7, 32'h00000080);
        issue(3'd3, 32'h2000, 32'h0, 32'h3, 5'd7);
        grant(1);
        respond(1, 32'h80FFFFFF);

        // SH with gnt held off 3 cycles
        push_req(32'h3000, 4'b1100, 1'b1, 32'hABCDABCD);
        issue(3'd6, 32'h3000, 32'h1234ABCD, 32'h2, 5'd3);
        for (int i = 0; i < 3; i++) begin
            chk("sh_req_hold", 32'(bus_req), 1);
            chk("sh_be_hold", 32'(bus_be), 32'hC);
            chk("sh_wd_hold", bus_wdata, 32'hABCDABCD);
            chk("sh_addr_hold", bus_addr, 32'h3000);
            step();
        end
        grant(0);
        respond(0, 32'h0);

        // SB / SW lanes
        push_req(32'h7000, 4'b0010, 1'b1, 32'hA5A5A5A5);
        issue(3'd5, 32'h7000, 32'h000000A5, 32'h1, 5'd0);
        grant(0);
        respond(0, 32'h0);
        push_req(32'h7004, 4'b1111, 1'b1, 32'hCAFEF00D);
        issue(3'd7, 32'h7008, 32'hCAFEF00D, 32'hFFFFFFFC, 5'd0);
        grant(0);
        respond(0, 32'h0);

        // LH upper half, LW to x0
        push_req(32'h4000, 4'b1100, 1'b0, 32'h0);
        push_wb(5'd8, 32'hFFFF8001);
        issue(3'd1, 32'h4000, 32'h0, 32'h2, 5'd8);
        grant(0);
        respond(0, 32'h80011234);
        push_req(32'h5000, 4'b1111, 1'b0, 32'h0);
        issue(3'd2, 32'h5000, 32'h0, 32'h0, 5'd0);
        grant(0);
        respond(0, 32'h11111111);

        // LHU timeout after 4 WAIT_RSP cycles
        push_req(32'h6000, 4'b1100, 1'b0, 32'h0);
        err_q.push_back(1);
        issue(3'd4, 32'h6000, 32'h0, 32'h2, 5'd9);
        grant(0);
        for (int i = 0; i < 4; i++) begin
            chk("to_no_err_yet", 32'(bus_err), 0);
            chk("to_busy", 32'(ls_rdy), 0);
            step();
        end
        chk("to_bus_err", 32'(bus_err), 1);
        chk("to_rdy", 32'(ls_rdy), 1);
        step();
        chk("to_err_pulse", 32'(bus_err), 0);

        // rsp in the timeout cycle wins
        push_req(32'h6100, 4'b1111, 1'b0, 32'h0);
        push_wb(5'd10, 32'h0BADF00D);
        issue(3'd2, 32'h6100, 32'h0, 32'h0, 5'd10);
        grant(0);
        respond(3, 32'h0BADF00D);
        chk("race_no_err", 32'(bus_err), 0);
        chk("race_wb", 32'(wb_vld), 1);

        // LH misaligned 0x4001
`ifdef PEAK_LSU_MISALIGN_EXC_EN
        exc_q.push_back(32'h4001);
        issue(3'd1, 32'h4000, 32'h0, 32'h1, 5'd11);
        chk("mis_pulse", 32'(misalign_exc), 1);
        chk("mis_no_req", 32'(bus_req), 0);
        chk("mis_rdy", 32'(ls_rdy), 1);
        step();
        chk("mis_no_req2", 32'(bus_req), 0);
`else
        push_req(32'h4000, 4'b0011, 1'b0, 32'h0);
        push_wb(5'd11, 32'hFFFFF00D);
        issue(3'd1, 32'h4000, 32'h0, 32'h1, 5'd11);
        grant(0);
        respond(0, 32'h0000F00D);
        chk("mis_tied", 32'(misalign_exc), 0);
`endif

        // reset while in REQ: bus_req drops without a clock edge
        issue(3'd2, 32'h8000, 32'h0, 32'h0, 5'd12);
        chk("rreq_req", 32'(bus_req), 1);
        #1 rst = 1'b1;
        #1;
        chk("rreq_async", 32'(bus_req), 0);
        chk("rreq_rdy", 32'(ls_rdy), 1);
        step();
        rst = 1'b0;
        step();

        // reset while in WAIT_RSP, stray rsp afterwards
        push_req(32'h9000, 4'b1111, 1'b0, 32'h0);
        issue(3'd2, 32'h9000, 32'h0, 32'h0, 5'd13);
        grant(0);
        rst = 1'b1;
        #1;
        chk("rwait_req", 32'(bus_req), 0);
        step();
        rst = 1'b0;
        respond(0, 32'h12345678);
        chk("rwait_no_wb", 32'(wb_vld), 0);
        chk("rwait_rdy", 32'(ls_rdy), 1);
        step();
        step();

        chk("req_q_empty", req_q.size(), 0);
        chk("wb_q_empty", wb_q.size(), 0);
        chk("err_q_empty", err_q.size(), 0);
        chk("exc_q_empty", exc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
